halflife_ctrl: RTL and testbench
================================

# halflife_ctrl

Command sequencer that drives the load/up/down command interface of the team's N-bit up/down count register and reads its count back. Once started, it loads an initial value and issues paced decrement strobes until the count reaches zero. It flags every half-life point (count halved since the last point) and optionally doubles the step interval at each point for exponential-style decay. It sits between the system control logic and the count register.

## Interface
- `N`, 4, count width; must match the count register.
- `PRESCALE_W`, 8, width of the step-interval timer and `period`.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  begin a decay run; sampled in IDLE only.
- `abort`  in  1  cancel a run; return to IDLE next cycle.
- `boost`  in  1  request one increment during a run.
- `init_val`  in  N  value to load; captured on accepted `start`.
- `period`  in  PRESCALE_W  WAIT cycles per step; captured on accepted `start`; 0 treated as 1.
- `count`  in  N  registered count fed back from the count register.
- `cmd_load`  out  1  load strobe to the count register.
- `cmd_up`  out  1  increment strobe.
- `cmd_down`  out  1  decrement strobe.
- `cmd_val`  out  N  load value; equals the captured init_val.
- `busy`  out  1  high in every state except IDLE.
- `half`  out  1  one-cycle pulse at each half-life point.
- `done`  out  1  one-cycle pulse on normal completion.

## Operation
- FSM states: IDLE, LOAD, SETTLE, WAIT, STEP, DONE.
- Outputs are Moore, decoded from the state register.
  - `cmd_load` is high in LOAD only; `cmd_down` in STEP only; `done` in DONE only.
  - `cmd_up` is high for exactly one cycle: the WAIT cycle in which a boost is accepted.
- IDLE: on `start` capture `init_val`, `period` (0 becomes 1) into `interval`, set `level` = `init_val`, go to LOAD.
- LOAD (1 cycle): go to SETTLE.
- SETTLE (1 cycle): `count` now reflects the previous command.
  - Half-life check, only after a STEP: if `count` ≤ `level`>>1, pulse `half` this cycle and set `level` = `count`.
  - Then, if `count`==0, go to DONE; else set `timer` = `interval` and go to WAIT.
- WAIT: decrement `timer` each cycle; when `timer`==1, go to STEP.
  - Boost: if `boost` is high and `count` != all-ones, assert `cmd_up`, set `level` = `count`+1, go to SETTLE.
  - If `boost` is high and `count` == all-ones, ignore it.
- STEP (1 cycle): go to SETTLE.
- DONE (1 cycle): go to IDLE.
- `abort` in any non-IDLE state forces IDLE on the next edge, with no `done` and no further commands. `abort` takes priority over `boost`.
- `start` while busy is ignored.
- At most one of `cmd_load`, `cmd_up`, `cmd_down` is high in any cycle.

## Timing
- Reset: state IDLE; all outputs 0; `cmd_val`, `interval`, `level` and `timer` cleared. The count register must receive the same `rst`.
- Accepted `start` in cycle 0 gives: LOAD in cycle 1, SETTLE in cycle 2, WAIT in cycles 3..2+P, STEP in cycle 3+P.
- Steady-state step period is `interval`+2 cycles (WAIT + STEP + SETTLE).
- `half` and `done` pulses: `half` is high in the SETTLE cycle. `done` is high in the cycle after the final SETTLE.
- `init_val`==0: LOAD, SETTLE, DONE; no `cmd_down`, no `half`; `done` in cycle 3.

## Configuration
- `HALFLIFE_DOUBLING_EN` defined:
  - At every `half` pulse, set `interval` = `interval`<<1.
  - Saturate at 2^PRESCALE_W−1.
  - The new interval applies from the WAIT that follows.
- Not defined: `interval` stays constant for the whole run. All other behaviour is identical.

## Test plan
- Constant interval, macro off: reset, then `init_val`=8, `period`=3, pulse `start`.
  - `cmd_load` in cycle 1 with `cmd_val`=8.
  - `cmd_down` every 5 cycles, 8 strobes in total.
  - `half` at counts 4, 2, 1, 0.
  - `done` once; `busy` low afterwards.
- Doubling, macro on: same stimulus as above.
  - WAIT lengths 3,3,3,3, then 6,6, then 12, then 24.
  - Also set `period`=200 with `init_val`=15 and confirm `interval` saturates at 255.
- Zero load: `init_val`=0.
  - No `cmd_down` and no `half`; `done` in cycle 3.
- Boost: `boost` pulsed during WAIT at count 5.
  - One-cycle `cmd_up`; count becomes 6; timer restarts.
  - Repeat at count 15 with N=4: no `cmd_up`.
- Abort and reset mid-run: assert `abort` in WAIT.
  - IDLE next cycle; no `done`; no further strobes.
  - Assert `rst` during STEP: all outputs 0 on the next cycle.
- Ignored start and period 0: `start` while busy has no effect; `period`=0 gives single-cycle WAITs.

Source files
------------

// File: rtl/halflife_ctrl.sv
// -----------------------------------------------------------------------------
// halflife_ctrl
//
// Command sequencer for an N-bit up/down count register. A run loads
// init_val, then issues paced decrement strobes until the fed-back count
// reaches zero. Every time the count has halved since the last half-life
// point, `half` pulses.
//
// Optional feature macro: HALFLIFE_DOUBLING_EN
//   defined   : step interval doubles (saturating) at each half-life point
//   undefined : step interval is constant for the whole run
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   start               begin a run (sampled in IDLE only)
//   abort               cancel a run, IDLE on the next edge
//   boost               request one increment while waiting
//   init_val [N]        load value, captured on accepted start
//   period   [PW]       WAIT cycles per step, captured on start (0 -> 1)
//   count    [N]        registered count from the count register
//   cmd_load/up/down    command strobes to the count register
//   cmd_val  [N]        load value presented with cmd_load
//   busy                high in every state except IDLE
//   half                one-cycle pulse at each half-life point
//   done                one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module halflife_ctrl #(
  parameter int N          = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  boost,
  input  logic [N-1:0]          init_val,
  input  logic [PRESCALE_W-1:0] period,
  input  logic [N-1:0]          count,
  output logic                  cmd_load,
  output logic                  cmd_up,
  output logic                  cmd_down,
  output logic [N-1:0]          cmd_val,
  output logic                  busy,
  output logic                  half,
  output logic                  done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_STEP   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [N-1:0]          CNT_MAX  = {N{1'b1}};
  localparam logic [N-1:0]          CNT_ZERO = {N{1'b0}};
  localparam logic [PRESCALE_W-1:0] ITV_MAX  = {PRESCALE_W{1'b1}};
  localparam logic [PRESCALE_W-1:0] ITV_ZERO = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] ITV_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]          CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

  state_t                  state_r, state_s;
  logic [PRESCALE_W-1:0]   interval_r, interval_s;
  logic [PRESCALE_W-1:0]   timer_r, timer_s;
  logic [N-1:0]            level_r, level_s;
  logic [N-1:0]            cmd_val_r, cmd_val_s;
  // The half-life check is only meaningful when the SETTLE follows a STEP.
  logic                    prev_step_r;
  logic                    up_s;
  logic                    half_s;

  // Interval to use after a half-life point.
  function automatic logic [PRESCALE_W-1:0] next_interval(input logic [PRESCALE_W-1:0] v);
`ifdef HALFLIFE_DOUBLING_EN
    if (v[PRESCALE_W-1]) begin
      return ITV_MAX;
    end else begin
      return {v[PRESCALE_W-2:0], 1'b0};
    end
`else
    return v;
`endif
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      interval_r  <= ITV_ZERO;
      timer_r     <= ITV_ZERO;
      level_r     <= CNT_ZERO;
      cmd_val_r   <= CNT_ZERO;
      prev_step_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      interval_r  <= interval_s;
      timer_r     <= timer_s;
      level_r     <= level_s;
      cmd_val_r   <= cmd_val_s;
      prev_step_r <= (state_r == ST_STEP);
    end
  end

  // Next-state, datapath updates and the two count-dependent strobes.
  always_comb begin
    state_s    = state_r;
    interval_s = interval_r;
    timer_s    = timer_r;
    level_s    = level_r;
    cmd_val_s  = cmd_val_r;
    up_s       = 1'b0;
    half_s     = 1'b0;

    if (abort && (state_r != ST_IDLE)) begin
      // Abort wins over everything, including a same-cycle boost.
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            cmd_val_s  = init_val;
            interval_s = (period == ITV_ZERO) ? ITV_ONE : period;
            level_s    = init_val;
            state_s    = ST_LOAD;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          state_s = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (prev_step_r && (count <= (level_r >> 1'b1))) begin
            half_s     = 1'b1;
            level_s    = count;
            interval_s = next_interval(interval_r);
          end else begin
            interval_s = interval_r;
          end
          if (count == CNT_ZERO) begin
            state_s = ST_DONE;
          end else begin
            // Uses the possibly-doubled interval so the new pace starts now.
            timer_s = interval_s;
            state_s = ST_WAIT;
          end
        end
        ST_WAIT: begin
          timer_s = timer_r - ITV_ONE;
          if (boost && (count != CNT_MAX)) begin
            up_s    = 1'b1;
            level_s = count + CNT_ONE;
            state_s = ST_SETTLE;
          end else if (timer_r == ITV_ONE) begin
            state_s = ST_STEP;
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_STEP: begin
          state_s = ST_SETTLE;
        end
        ST_DONE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_load = (state_r == ST_LOAD);
  assign cmd_down = (state_r == ST_STEP);
  assign done     = (state_r == ST_DONE);
  assign busy     = (state_r != ST_IDLE);
  assign cmd_up   = up_s;
  assign half     = half_s;
  assign cmd_val  = cmd_val_r;

endmodule

// File: tb/tb_halflife_ctrl.sv
// -----------------------------------------------------------------------------
// tb_halflife_ctrl
//
// Drives halflife_ctrl together with a behavioural count register. A run is
// predicted up front as a per-cycle schedule of expected strobes, built from
// the run rules (load, settle, WAIT windows of `interval` cycles, step,
// boosts, half-life points), then replayed and compared cycle by cycle.
// Honours HALFLIFE_DOUBLING_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_halflife_ctrl;

  localparam int N    = 4;
  localparam int PW   = 8;
  localparam int MAXC = 4200;

  logic          clk = 1'b0;
  logic          rst, start, abort, boost;
  logic [N-1:0]  init_val;
  logic [PW-1:0] period;
  logic [N-1:0]  count;
  logic          cmd_load, cmd_up, cmd_down, busy, half, done;
  logic [N-1:0]  cmd_val;

  always #5 clk = ~clk;

  halflife_ctrl #(.N(N), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .boost(boost),
    .init_val(init_val), .period(period), .count(count),
    .cmd_load(cmd_load), .cmd_up(cmd_up), .cmd_down(cmd_down),
    .cmd_val(cmd_val), .busy(busy), .half(half), .done(done)
  );

  // Count register the sequencer talks to.
  always_ff @(posedge clk) begin
    if (rst)           count <= '0;
    else if (cmd_load) count <= cmd_val;
    else if (cmd_up)   count <= count + 4'd1;
    else if (cmd_down) count <= count - 4'd1;
  end

  bit e_load[MAXC], e_up[MAXC], e_down[MAXC], e_half[MAXC];
  bit e_done[MAXC], e_busy[MAXC], e_wait[MAXC], bplan[MAXC];
  int e_cnt[MAXC];
  int run_end;
  int n_checks = 0;
  int n_err    = 0;
  int cyc;
  logic [N-1:0] exp_val;
  int obs_down, obs_up, obs_half, obs_done;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected schedule of one run started in cycle 0.
  task automatic build(input int iv, input int p);
    int cnt, lvl, itv, s, w, b;
    bit after;
    for (int c = 0; c < MAXC; c++) begin
      e_load[c] = 0; e_up[c] = 0; e_down[c] = 0; e_half[c] = 0;
      e_done[c] = 0; e_busy[c] = 0; e_wait[c] = 0; e_cnt[c] = -1;
    end
    cnt = iv; lvl = iv; itv = (p == 0) ? 1 : p;
    e_load[1] = 1; e_busy[1] = 1; e_busy[2] = 1;
    s = 2; after = 0;
    while (1) begin
      if (after && (cnt <= lvl / 2)) begin
        e_half[s] = 1;
        lvl = cnt;
`ifdef HALFLIFE_DOUBLING_EN
        itv = (itv * 2 > 255) ? 255 : itv * 2;
`endif
      end
      if (cnt == 0) begin
        e_done[s+1] = 1; e_busy[s+1] = 1; run_end = s + 1;
        break;
      end
      if (s + itv + 3 >= MAXC) begin
        run_end = s;
        break;
      end
      w = s + 1; b = -1;
      for (int k = w; k < w + itv; k++) begin
        e_wait[k] = 1; e_busy[k] = 1;
        if (bplan[k] && cnt != 15) begin
          b = k;
          break;
        end
      end
      if (b >= 0) begin
        e_up[b] = 1; cnt++; lvl = cnt; s = b + 1; after = 0;
      end else begin
        e_down[w+itv] = 1; e_busy[w+itv] = 1; cnt--; s = w + itv + 1; after = 1;
      end
      e_busy[s] = 1;
      e_cnt[s] = cnt;
    end
  endtask

  // Truncate the schedule after an abort/reset cycle.
  task automatic apply_cut(input int cut, input bit is_abort);
    if (is_abort) e_up[cut] = 0;
    for (int c = cut + 1; c < MAXC; c++) begin
      e_load[c] = 0; e_up[c] = 0; e_down[c] = 0; e_half[c] = 0;
      e_done[c] = 0; e_busy[c] = 0; e_cnt[c] = -1;
    end
    run_end = cut;
  endtask

  // kind: 0 normal, 1 abort in a random WAIT cycle, 2 reset in first STEP.
  task automatic run(input int iv, input int p, input int kind, input bit noise);
    int cut, n, idx, len;
    cut = -1;
    build(iv, p);
    if (kind == 1) begin
      n = 0;
      for (int c = 0; c < MAXC; c++) if (e_wait[c]) n++;
      if (n > 0) begin
        idx = $urandom_range(0, n - 1);
        for (int c = 0; c < MAXC; c++) begin
          if (e_wait[c]) begin
            if (idx == 0) begin cut = c; break; end
            idx--;
          end
        end
        apply_cut(cut, 1'b1);
      end
    end else if (kind == 2) begin
      for (int c = 0; c < MAXC; c++) if (e_down[c]) begin cut = c; break; end
      if (cut >= 0) apply_cut(cut, 1'b0);
    end
    obs_down = 0; obs_up = 0; obs_half = 0; obs_done = 0;
    len = run_end + 3;
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      cyc      = c;
      start    = (c == 0) ? 1'b1 : (noise && e_busy[c] && ($urandom_range(0, 3) == 0));
      init_val = (c == 0) ? iv[N-1:0] : N'($urandom);
      period   = (c == 0) ? p[PW-1:0] : PW'($urandom);
      boost    = bplan[c];
      abort    = (kind == 1) && (c == cut);
      rst      = (kind == 2) && (c == cut);
      @(negedge clk);
      if (c == 1) exp_val = iv[N-1:0];
      if ((kind == 2) && (cut >= 0) && (c == cut + 1)) exp_val = '0;
      chk_eq("cmd_load", cmd_load, e_load[c]);
      chk_eq("cmd_up",   cmd_up,   e_up[c]);
      chk_eq("cmd_down", cmd_down, e_down[c]);
      chk_eq("half",     half,     e_half[c]);
      chk_eq("done",     done,     e_done[c]);
      chk_eq("busy",     busy,     e_busy[c]);
      chk_eq("cmd_val",  cmd_val,  exp_val);
      if (e_cnt[c] >= 0) chk_eq("count", count, e_cnt[c]);
      obs_down += cmd_down; obs_up += cmd_up; obs_half += half; obs_done += done;
    end
    start = 0; boost = 0; abort = 0; rst = 0;
  endtask

  task automatic clear_plan();
    for (int c = 0; c < MAXC; c++) bplan[c] = 0;
  endtask

  initial begin
    int d, iv, p, kind;
    rst = 1; start = 0; abort = 0; boost = 0; init_val = '0; period = '0;
    exp_val = '0; cyc = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_cmds", {cmd_load, cmd_up, cmd_down, half, done}, 0);
    chk_eq("rst_val",  cmd_val, 0);
    @(posedge clk); #1 rst = 0;

    // Constant/doubling reference run: 8 from period 3.
    clear_plan();
    run(8, 3, 0, 1'b0);
    chk_eq("t1_downs", obs_down, 8);
    chk_eq("t1_halves", obs_half, 4);
    chk_eq("t1_dones", obs_done, 1);

    // Long interval, exercises saturation when doubling is built in.
    run(15, 200, 0, 1'b0);

    // Zero load.
    run(0, 5, 0, 1'b1);
    chk_eq("zero_downs", obs_down, 0);
    chk_eq("zero_halves", obs_half, 0);

    // Boost in the second WAIT cycle at count 5.
    build(8, 4);
    d = -1;
    for (int c = 0, k = 0; c < MAXC; c++) if (e_down[c]) begin k++; if (k == 3) begin d = c; break; end end
    bplan[d+3] = 1;
    run(8, 4, 0, 1'b0);
    chk_eq("boost_ups", obs_up, 1);
    clear_plan();

    // Boost at all-ones is ignored.
    bplan[4] = 1;
    run(15, 3, 0, 1'b0);
    chk_eq("sat_ups", obs_up, 0);
    clear_plan();

    // Abort mid-run, reset mid-run, period 0 with start noise.
    run(9, 2, 1, 1'b1);
    run(6, 2, 2, 1'b0);
    run(7, 0, 0, 1'b1);

    // Randomized runs.
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < MAXC; c++) bplan[c] = ($urandom_range(0, 7) == 0);
      iv   = $urandom_range(0, 15);
      p    = $urandom_range(0, 4);
      kind = ($urandom_range(0, 3) == 0) ? 1 : 0;
      run(iv, p, kind, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
